// File: rtl/uart_rx_core_if.sv
// Bundle of serial-line, configuration and result signals for uart_rx_core.
// The testbench or upstream logic uses the master modport, and the receiver core uses the slave modport.
// err_cnt exists only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESC_W-1:0]    Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, data_valid, par_err, stp_err
`ifdef UART_RX_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, data_valid, par_err, stp_err
`ifdef UART_RX_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive frame engine.
// The core oversamples RX_IN at Prescale samples per bit and takes a 3-sample majority vote in the middle of each bit.
// Data is assembled LSB-first.
// It checks optional parity and the stop bit, and pulses data_valid for one cycle when a frame is received cleanly.
// Optional feature: when UART_RX_ERR_CNT_EN is defined, the core adds a saturating 8-bit count of errored frames (err_cnt).
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_core_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_WIDTH + 3);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [PRESC_W-1:0]    edge_cnt;
  logic [PRESC_W-1:0]    prescale_q;
  logic [PRESC_W-1:0]    half;
  logic [BIT_W-1:0]      bit_cnt;
  logic [2:0]            samples;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;
  logic                  voted;
  logic                  bit_end;
  logic                  vote_pt;
  logic                  expected_par;

  assign half         = prescale_q >> 1;
  assign voted        = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
  assign bit_end      = (edge_cnt == prescale_q - PRESC_W'(1));
  assign vote_pt      = (edge_cnt == half + PRESC_W'(2));
  assign expected_par = (^shift_reg) ^ par_typ_q;

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;

  // Frame FSM: the counters, the mid-bit sampling, the shift register, the error flags and the result registers all update here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      samples      <= '0;
      shift_reg    <= '0;
      p_data_q     <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;

      if (state != IDLE) begin
        if (bit_end) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + BIT_W'(1);
        end else begin
          edge_cnt <= edge_cnt + PRESC_W'(1);
        end
        if (edge_cnt == half - PRESC_W'(1)) samples[0] <= bus.RX_IN;
        if (edge_cnt == half)               samples[1] <= bus.RX_IN;
        if (edge_cnt == half + PRESC_W'(1)) samples[2] <= bus.RX_IN;
      end

      case (state)
        IDLE: begin
          if (!bus.RX_IN) begin
            state      <= START;
            edge_cnt   <= PRESC_W'(1);
            bit_cnt    <= '0;
            prescale_q <= bus.Prescale;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) state <= voted ? IDLE : DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {voted, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_DATA_BIT) state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (vote_pt && (voted != expected_par)) par_err_q <= 1'b1;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (vote_pt && !voted) stp_err_q <= 1'b1;
          if (bit_end) begin
            state <= IDLE;
            if (!par_err_q && !stp_err_q) begin
              p_data_q     <= shift_reg;
              data_valid_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  assign bus.err_cnt = err_cnt_q;

  // Saturating count of frames that end with a parity or stop error; a frame with both errors counts once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_q <= '0;
    end else if (state == STOP && bit_end && (par_err_q || stp_err_q) && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core.
// It drives whole frames onto RX_IN at negative clock edges and compares the outputs with hand-computed values.
// The checks cover reset, plain frames, parity, stop errors, glitch rejection, back-to-back frames and a mid-frame reset.
module tb_uart_rx_core;
  logic CLK;
  logic RST;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   strobe_cnt = 0;
  int   last_strobe_cyc = 0;
  int   prev_strobe_cyc = 0;
  logic [7:0] last_strobe_data = '0;
  logic [7:0] prev_strobe_data = '0;
  int   start_cyc = 0;
  int   sc0;

  uart_rx_core_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

  uart_rx_core #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Free-running 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count rising edges so that the bench can measure the strobe latency
  always @(posedge CLK) cyc <= cyc + 1;

  // Record every data_valid strobe together with its cycle and data
  always @(negedge CLK) begin
    if (bus.data_valid === 1'b1) begin
      strobe_cnt++;
      prev_strobe_cyc  = last_strobe_cyc;
      prev_strobe_data = last_strobe_data;
      last_strobe_cyc  = cyc;
      last_strobe_data = bus.P_DATA;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one full frame starting at the current negedge and returns at the negedge where a strobe would be visible
  task automatic applyStimulus(input int presc, input logic par_en, input logic par_typ,
                               input logic [7:0] data, input logic par_bit, input logic stop_bit);
    bus.Prescale = 6'(presc);
    bus.PAR_EN   = par_en;
    bus.PAR_TYP  = par_typ;
    start_cyc    = cyc;
    bus.RX_IN    = 1'b0;
    repeat (presc) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      bus.RX_IN = data[i];
      repeat (presc) @(negedge CLK);
    end
    if (par_en) begin
      bus.RX_IN = par_bit;
      repeat (presc) @(negedge CLK);
    end
    bus.RX_IN = stop_bit;
    repeat (presc) @(negedge CLK);
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    RST          = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    checkOutput("reset_p_data", bus.P_DATA, 8'h00);
    checkOutput("reset_valid", bus.data_valid, 1'b0);
    checkOutput("reset_par_err", bus.par_err, 1'b0);
    checkOutput("reset_stp_err", bus.stp_err, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
    checkOutput("reset_err_cnt", bus.err_cnt, 8'd0);
`endif
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // Test 1: 0xA5, Prescale 8, no parity; the strobe is expected 80 cycles after the start edge
    sc0 = strobe_cnt;
    applyStimulus(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    checkOutput("t1_strobes", strobe_cnt - sc0, 1);
    checkOutput("t1_latency", last_strobe_cyc - start_cyc, 80);
    checkOutput("t1_p_data", bus.P_DATA, 8'hA5);
    checkOutput("t1_strobe_data", last_strobe_data, 8'hA5);
    checkOutput("t1_par_err", bus.par_err, 1'b0);
    checkOutput("t1_stp_err", bus.stp_err, 1'b0);
    checkOutput("t1_valid_low", bus.data_valid, 1'b0);

    // Test 2a: even parity; 0xA5 has four ones, so the correct parity bit is 0
    sc0 = strobe_cnt;
    applyStimulus(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    checkOutput("t2a_strobes", strobe_cnt - sc0, 1);
    checkOutput("t2a_latency", last_strobe_cyc - start_cyc, 88);
    checkOutput("t2a_par_err", bus.par_err, 1'b0);

    // Test 2b: wrong parity bit
    sc0 = strobe_cnt;
    applyStimulus(8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    repeat (2) @(negedge CLK);
    checkOutput("t2b_strobes", strobe_cnt - sc0, 0);
    checkOutput("t2b_par_err", bus.par_err, 1'b1);
    checkOutput("t2b_p_data", bus.P_DATA, 8'hA5);
`ifdef UART_RX_ERR_CNT_EN
    checkOutput("t2b_err_cnt", bus.err_cnt, 8'd1);
`endif

    // Test 3: stop bit low at Prescale 16
    sc0 = strobe_cnt;
    applyStimulus(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    checkOutput("t3_strobes", strobe_cnt - sc0, 0);
    checkOutput("t3_stp_err", bus.stp_err, 1'b1);
    checkOutput("t3_par_err", bus.par_err, 1'b0);
    checkOutput("t3_p_data", bus.P_DATA, 8'hA5);
`ifdef UART_RX_ERR_CNT_EN
    checkOutput("t3_err_cnt", bus.err_cnt, 8'd2);
`endif

    // Test 4: a 2-cycle glitch is rejected; a valid 0x5A frame follows
    sc0 = strobe_cnt;
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    repeat (2) @(negedge CLK);
    bus.RX_IN    = 1'b1;
    repeat (24) @(negedge CLK);
    checkOutput("t4_glitch_strobes", strobe_cnt - sc0, 0);
    checkOutput("t4_glitch_stp_err", bus.stp_err, 1'b0);
    checkOutput("t4_glitch_par_err", bus.par_err, 1'b0);
    applyStimulus(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    checkOutput("t4_strobes", strobe_cnt - sc0, 1);
    checkOutput("t4_p_data", bus.P_DATA, 8'h5A);

    // Test 5: odd parity at Prescale 32 with back-to-back frames; each data value has four ones, so the parity bit is 1
    sc0 = strobe_cnt;
    applyStimulus(32, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    applyStimulus(32, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
    repeat (2) @(negedge CLK);
    checkOutput("t5_strobes", strobe_cnt - sc0, 2);
    checkOutput("t5_spacing", last_strobe_cyc - prev_strobe_cyc, 352);
    checkOutput("t5_first_data", prev_strobe_data, 8'h3C);
    checkOutput("t5_second_data", last_strobe_data, 8'hC3);
    checkOutput("t5_p_data", bus.P_DATA, 8'hC3);
    checkOutput("t5_par_err", bus.par_err, 1'b0);

    // Test 6: reset asserted during data bit 4; a 0xFF frame follows
    sc0 = strobe_cnt;
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      bus.RX_IN = i[0];
      repeat (8) @(negedge CLK);
    end
    bus.RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("t6_rst_p_data", bus.P_DATA, 8'h00);
    checkOutput("t6_rst_valid", bus.data_valid, 1'b0);
    checkOutput("t6_rst_par_err", bus.par_err, 1'b0);
    checkOutput("t6_rst_stp_err", bus.stp_err, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
    checkOutput("t6_rst_err_cnt", bus.err_cnt, 8'd0);
`endif
    @(negedge CLK);
    RST       = 1'b1;
    bus.RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("t6_abort_strobes", strobe_cnt - sc0, 0);
    applyStimulus(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    checkOutput("t6_strobes", strobe_cnt - sc0, 1);
    checkOutput("t6_p_data", bus.P_DATA, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
